// File: rtl/isa_pkg.sv
// Shared RV64 ISA constants: major opcodes and funct3 encodings for loads and stores.
package isa_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store unit types: controller states, access sizes and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // Encoding matches funct3[1:0] of the RV64 load/store instructions.
  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W,
    SIZE_D
  } lsu_size_e;

  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between the 64-bit memory word and a B/H/W/D access:
// store strobes and data shift, and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  lsu_size_e       size,
  input  logic [2:0]      offset,
  input  logic            store_en,
  input  logic            sign_ext,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]      size_mask;
  logic [5:0]      bit_shift;
  logic [XLEN-1:0] rdata_shifted;

  assign bit_shift     = {offset, 3'b000};
  assign wdata         = store_data << bit_shift;
  assign rdata_shifted = mem_rdata >> bit_shift;
  assign wstrb         = store_en ? (size_mask << offset) : 8'h00;

  always_comb begin
    size_mask = 8'hFF;
    case (size)
      SIZE_B:  size_mask = 8'h01;
      SIZE_H:  size_mask = 8'h03;
      SIZE_W:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  always_comb begin
    load_data = rdata_shifted;
    case (size)
      SIZE_B:  load_data = {{(XLEN-8){sign_ext & rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_H:  load_data = {{(XLEN-16){sign_ext & rdata_shifted[15]}}, rdata_shifted[15:0]};
      SIZE_W:  load_data = {{(XLEN-32){sign_ext & rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_data = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding RV64 load/store controller: decodes the instruction at
// acceptance, raises alignment/illegal exceptions, and runs one dmem transaction.
module lsu_ctrl
  import isa_pkg::*;
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_inst,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_wdata,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            done_valid,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_misaligned,
  output logic            exc_illegal
);

  lsu_state_e      state, state_next;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            dec_load, dec_store, dec_legal, dec_misaligned, dec_unsigned;
  lsu_size_e       dec_size;
  logic [11:0]     imm12;
  logic [XLEN-1:0] imm_ext, eff_addr;
  logic            accept;
  logic            unused_rs1;

  logic [XLEN-1:0] addr_q, store_data_q, load_data_q;
  lsu_size_e       size_q;
  logic            load_q, sign_q, exc_mis_q, exc_ill_q;
  logic [4:0]      rd_q;

  logic [7:0]      align_wstrb;
  logic [XLEN-1:0] align_wdata, align_load;

  assign opcode         = req_inst[6:0];
  assign funct3         = req_inst[14:12];
  assign unused_rs1     = ^req_inst[19:15];
  assign dec_load       = (opcode == OPC_LOAD) &&
                          (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU});
  assign dec_store      = (opcode == OPC_STORE) && (funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD});
  assign dec_legal      = dec_load || dec_store;
  assign dec_unsigned   = funct3 inside {F3_LBU, F3_LHU, F3_LWU};
  assign dec_size       = lsu_size_e'(funct3[1:0]);
  assign imm12          = dec_store ? {req_inst[31:25], req_inst[11:7]} : req_inst[31:20];
  assign imm_ext        = {{(XLEN-12){imm12[11]}}, imm12};
  assign eff_addr       = req_base + imm_ext;
  assign dec_misaligned = is_misaligned(dec_size, eff_addr[2:0]);
  assign accept         = req_valid && (state == ST_IDLE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .size       (size_q),
    .offset     (addr_q[2:0]),
    .store_en   ((state == ST_ISSUE) && !load_q),
    .sign_ext   (sign_q),
    .store_data (store_data_q),
    .mem_rdata  (dmem_rdata),
    .wstrb      (align_wstrb),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    dmem_req_valid = 1'b0;
    done_valid     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (!dec_legal || dec_misaligned) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) begin
          state_next = load_q ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (dmem_resp_valid) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture at acceptance; the load result is cleared then so stores
  // and exceptions never expose stale data on wb_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      store_data_q <= '0;
      load_data_q  <= '0;
      size_q       <= SIZE_B;
      load_q       <= 1'b0;
      sign_q       <= 1'b0;
      exc_mis_q    <= 1'b0;
      exc_ill_q    <= 1'b0;
      rd_q         <= '0;
    end else begin
      if (accept) begin
        addr_q       <= eff_addr;
        store_data_q <= req_wdata;
        load_data_q  <= '0;
        size_q       <= dec_size;
        load_q       <= dec_load;
        sign_q       <= !dec_unsigned;
        exc_mis_q    <= dec_legal && dec_misaligned;
        exc_ill_q    <= !dec_legal;
        rd_q         <= req_inst[11:7];
      end
      if ((state == ST_WAIT) && dmem_resp_valid) begin
        load_data_q <= align_load;
      end
    end
  end

  assign dmem_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_we        = (state == ST_ISSUE) && !load_q;
  assign dmem_wdata     = align_wdata;
  assign dmem_wstrb     = align_wstrb;
  assign exc_misaligned = (state == ST_DONE) && exc_mis_q;
  assign exc_illegal    = (state == ST_DONE) && exc_ill_q;
  assign wb_en          = (state == ST_DONE) && load_q && !exc_mis_q && !exc_ill_q && (rd_q != 5'd0);
  assign wb_rd          = rd_q;
  assign wb_data        = load_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, a stall/reset-abort
// sequence, and randomized operations checked against a byte-level reference model.
module tb_lsu_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_inst;
  logic [63:0] req_base, req_wdata;
  logic        dmem_req_valid, dmem_req_ready;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we, dmem_resp_valid;
  logic [7:0]  dmem_wstrb;
  logic        done_valid, wb_en, exc_misaligned, exc_illegal;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [63:0] base, wdata, rdata;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic        exp_wb_en;
    logic [63:0] exp_wb_data;
    logic        exp_mis, exp_ill;
  } vec_t;

  typedef struct {
    int          lat, first_req, unstable, busy_ready, stalls;
    logic        saw_req;
    logic [63:0] addr, wdata;
    logic        we;
    logic [7:0]  wstrb;
    logic        wb_en, mis, ill, pulse_extra, idle_after;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
  } obs_t;

  lsu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
    .req_base(req_base), .req_wdata(req_wdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .done_valid(done_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] enc_load(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_store(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] inst, input logic [63:0] base,
                              input logic [63:0] wdata, input logic [63:0] rdata, input logic exp_req,
                              input logic [63:0] exp_addr, input logic exp_we, input logic [7:0] exp_wstrb,
                              input logic [63:0] exp_wdata, input logic exp_wb_en, input logic [63:0] exp_wb_data,
                              input logic exp_mis, input logic exp_ill);
    vec_t v;
    v.name = name; v.inst = inst; v.base = base; v.wdata = wdata; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_wstrb = exp_wstrb;
    v.exp_wdata = exp_wdata; v.exp_wb_en = exp_wb_en; v.exp_wb_data = exp_wb_data;
    v.exp_mis = exp_mis; v.exp_ill = exp_ill;
    return v;
  endfunction

  // Reference model: works on byte counts and integer arithmetic.
  function automatic vec_t model(input logic [31:0] inst, input logic [63:0] base,
                                 input logic [63:0] wdata, input logic [63:0] rdata);
    vec_t   v;
    int     f3, nbytes, off;
    bit     is_ld, is_st;
    longint imm;
    logic [63:0] ea, mask, val;
    logic [11:0] ifield;
    v.name = "rnd"; v.inst = inst; v.base = base; v.wdata = wdata; v.rdata = rdata;
    f3     = int'(inst[14:12]);
    is_ld  = (inst[6:0] == 7'b0000011) && (f3 <= 6);
    is_st  = (inst[6:0] == 7'b0100011) && (f3 <= 3);
    nbytes = 1 << (f3 % 4);
    ifield = is_st ? {inst[31:25], inst[11:7]} : inst[31:20];
    imm    = longint'($signed(ifield));
    ea     = base + 64'(imm);
    off    = int'(ea % 8);
    v.exp_ill   = !(is_ld || is_st);
    v.exp_mis   = !v.exp_ill && ((ea % nbytes) != 0);
    v.exp_req   = !v.exp_ill && !v.exp_mis;
    v.exp_addr  = ea - 64'(off);
    v.exp_we    = is_st;
    v.exp_wstrb = '0;
    for (int i = 0; i < 8; i++) begin
      if (is_st && i >= off && i < off + nbytes) v.exp_wstrb[i] = 1'b1;
    end
    v.exp_wdata = wdata << (8 * off);
    val = rdata >> (8 * off);
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      val  = val & mask;
      if (f3 < 4 && val[8*nbytes-1]) val = val | ~mask;
    end
    v.exp_wb_data = val;
    v.exp_wb_en   = v.exp_req && is_ld && (inst[11:7] != 5'd0);
    return v;
  endfunction

  // Plays the requester and a memory that answers resp_delay cycles after the
  // cycle following the handshake; optionally waves spurious responses in ISSUE.
  task automatic apply_stimulus(input vec_t v, input int ready_pct, input int resp_delay,
                                input bit junk, output obs_t o);
    bit hs_done, done_seen;
    int hs_cycle;
    o = '{default: 0};
    o.lat = -1; o.first_req = -1;
    hs_done = 0; done_seen = 0; hs_cycle = 0;
    @(negedge clk);
    req_valid = 1'b1; req_inst = v.inst; req_base = v.base; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_inst = $urandom; req_base = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    for (int n = 1; n <= 60 && !done_seen; n++) begin
      if (n > 1) @(negedge clk);
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = {$urandom, $urandom};
      if (done_valid) begin
        done_seen = 1; o.lat = n;
        o.wb_en = wb_en; o.wb_rd = wb_rd; o.wb_data = wb_data;
        o.mis = exc_misaligned; o.ill = exc_illegal;
      end else begin
        if (req_ready) o.busy_ready++;
        if (dmem_req_valid) begin
          if (!o.saw_req) begin
            o.saw_req = 1; o.first_req = n;
            o.addr = dmem_addr; o.we = dmem_we; o.wstrb = dmem_wstrb; o.wdata = dmem_wdata;
          end else if (dmem_addr !== o.addr || dmem_we !== o.we || dmem_wstrb !== o.wstrb ||
                       dmem_wdata !== o.wdata) begin
            o.unstable++;
          end
          if (int'($urandom_range(99)) < ready_pct) begin
            dmem_req_ready = 1'b1; hs_done = 1; hs_cycle = n;
          end else begin
            o.stalls++;
          end
        end
        if (hs_done && n == hs_cycle + 1 + resp_delay) begin
          dmem_resp_valid = 1'b1; dmem_rdata = v.rdata;
        end else if (junk && (!hs_done || n == hs_cycle) && $urandom_range(1) == 1) begin
          dmem_resp_valid = 1'b1;
        end
      end
    end
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    @(negedge clk);
    o.pulse_extra = done_valid;
    o.idle_after  = req_ready;
  endtask

  task automatic check_op(input vec_t v, input obs_t o, input int resp_delay);
    int exp_lat;
    if (!v.exp_req)    exp_lat = 1;
    else if (v.exp_we) exp_lat = 2 + o.stalls;
    else               exp_lat = 3 + o.stalls + resp_delay;
    check_output({v.name, " latency"}, 64'(o.lat), 64'(exp_lat));
    check_output({v.name, " dmem_req_seen"}, 64'(o.saw_req), 64'(v.exp_req));
    if (v.exp_req) begin
      check_output({v.name, " first_req_cycle"}, 64'(o.first_req), 64'd1);
      check_output({v.name, " dmem_addr"}, o.addr, v.exp_addr);
      check_output({v.name, " dmem_we"}, 64'(o.we), 64'(v.exp_we));
      check_output({v.name, " dmem_wstrb"}, 64'(o.wstrb), 64'(v.exp_wstrb));
      if (v.exp_we) check_output({v.name, " dmem_wdata"}, o.wdata, v.exp_wdata);
      check_output({v.name, " req_fields_unstable"}, 64'(o.unstable), 64'd0);
    end
    check_output({v.name, " req_ready_busy"}, 64'(o.busy_ready), 64'd0);
    check_output({v.name, " wb_en"}, 64'(o.wb_en), 64'(v.exp_wb_en));
    check_output({v.name, " wb_rd"}, 64'(o.wb_rd), 64'(v.inst[11:7]));
    if (v.exp_wb_en) check_output({v.name, " wb_data"}, o.wb_data, v.exp_wb_data);
    check_output({v.name, " exc_misaligned"}, 64'(o.mis), 64'(v.exp_mis));
    check_output({v.name, " exc_illegal"}, 64'(o.ill), 64'(v.exp_ill));
    check_output({v.name, " done_pulse_width"}, 64'(o.pulse_extra), 64'd0);
    check_output({v.name, " idle_after"}, 64'(o.idle_after), 64'd1);
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_t        table_q[$];
    vec_t        v;
    obs_t        o;
    logic [31:0] inst;
    logic [63:0] base;
    logic [11:0] imm;
    logic [4:0]  rd;
    int          kind, delay, pct, pulses;

    rst_n = 1'b0; req_valid = 1'b0; req_inst = '0; req_base = '0; req_wdata = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;

    repeat (2) @(negedge clk);
    check_output("reset req_ready", 64'(req_ready), 64'd1);
    check_output("reset dmem_req_valid", 64'(dmem_req_valid), 64'd0);
    check_output("reset dmem_addr", dmem_addr, 64'd0);
    check_output("reset dmem_we_wstrb", {55'd0, dmem_we, dmem_wstrb}, 64'd0);
    check_output("reset dmem_wdata", dmem_wdata, 64'd0);
    check_output("reset done_exc_wb", {59'd0, done_valid, wb_en, exc_misaligned, exc_illegal, |wb_rd}, 64'd0);
    check_output("reset wb_data", wb_data, 64'd0);
    rst_n = 1'b1;

    table_q.push_back(mk("LB", enc_load(3'b000, 5'd5, 12'd3), 64'h1000, 64'h0, 64'h0000_0000_8000_0000,
                         1, 64'h1000, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 0));
    table_q.push_back(mk("SH", enc_store(3'b001, 12'd6), 64'h2000, 64'hABCD, 64'h0,
                         1, 64'h2000, 1, 8'hC0, 64'hABCD_0000_0000_0000, 0, 64'h0, 0, 0));
    table_q.push_back(mk("LW_mis", enc_load(3'b010, 5'd7, 12'd2), 64'h1000, 64'h0, 64'h0,
                         0, 64'h0, 0, 8'h00, 64'h0, 0, 64'h0, 1, 0));
    table_q.push_back(mk("LWU_wrap", enc_load(3'b110, 5'd10, 12'd4), 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,
                         64'h1234_5678_FFFF_FFFF, 1, 64'h0, 0, 8'h00, 64'h0, 1, 64'h0000_0000_FFFF_FFFF, 0, 0));
    table_q.push_back(mk("LD_rd0", enc_load(3'b011, 5'd0, 12'd8), 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF,
                         1, 64'h3008, 0, 8'h00, 64'h0, 0, 64'h0, 0, 0));
    table_q.push_back(mk("ADDI_ill", 32'h0000_0013, 64'h0, 64'h0, 64'h0,
                         0, 64'h0, 0, 8'h00, 64'h0, 0, 64'h0, 0, 1));
    table_q.push_back(mk("SD_negimm", enc_store(3'b011, 12'hFF8), 64'h4000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,
                         1, 64'h3FF8, 1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0, 0, 0));
    table_q.push_back(mk("LHU", enc_load(3'b101, 5'd3, 12'd6), 64'h5000, 64'h0, 64'h8001_0000_0000_0000,
                         1, 64'h5000, 0, 8'h00, 64'h0, 1, 64'h0000_0000_0000_8001, 0, 0));
    table_q.push_back(mk("LH", enc_load(3'b001, 5'd4, 12'd6), 64'h5000, 64'h0, 64'h8001_0000_0000_0000,
                         1, 64'h5000, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8001, 0, 0));
    table_q.push_back(mk("SH_mis", enc_store(3'b001, 12'd0), 64'h5001, 64'h1234, 64'h0,
                         0, 64'h0, 0, 8'h00, 64'h0, 0, 64'h0, 1, 0));
    table_q.push_back(mk("LOAD_f3_7", enc_load(3'b111, 5'd1, 12'd0), 64'h8000, 64'h0, 64'h0,
                         0, 64'h0, 0, 8'h00, 64'h0, 0, 64'h0, 0, 1));
    table_q.push_back(mk("STORE_f3_4", enc_store(3'b100, 12'd0), 64'h8000, 64'h0, 64'h0,
                         0, 64'h0, 0, 8'h00, 64'h0, 0, 64'h0, 0, 1));
    table_q.push_back(mk("SB_top", enc_store(3'b000, 12'hFFF), 64'h6008, 64'h5A, 64'h0,
                         1, 64'h6000, 1, 8'h80, 64'h5A00_0000_0000_0000, 0, 64'h0, 0, 0));
    table_q.push_back(mk("LW_hi", enc_load(3'b010, 5'd31, 12'd4), 64'h7000, 64'h0, 64'h8765_4321_0000_0000,
                         1, 64'h7000, 0, 8'h00, 64'h0, 1, 64'hFFFF_FFFF_8765_4321, 0, 0));

    $display("[TB] directed table: %0d vectors", table_q.size());
    foreach (table_q[i]) begin
      apply_stimulus(table_q[i], 100, 1, 1'b1, o);
      check_op(table_q[i], o, 1);
    end

    $display("[TB] stall and reset-abort sequence");
    @(negedge clk);
    req_valid = 1'b1; req_inst = enc_load(3'b011, 5'd9, 12'h010); req_base = 64'h6000; req_wdata = 64'h55;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dmem_req_ready = 1'b0;
      check_output("stall dmem_req_valid", 64'(dmem_req_valid), 64'd1);
      check_output("stall dmem_addr", dmem_addr, 64'h6010);
      check_output("stall dmem_we_wstrb", {55'd0, dmem_we, dmem_wstrb}, 64'd0);
      check_output("stall req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    check_output("wait dmem_req_valid", 64'(dmem_req_valid), 64'd0);
    check_output("wait req_ready", 64'(req_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort req_ready", 64'(req_ready), 64'd1);
    check_output("abort outputs", {61'd0, done_valid, dmem_req_valid, wb_en}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      dmem_resp_valid = 1'b1; dmem_rdata = 64'hFFFF_0000_FFFF_0000;
      if (done_valid) pulses++;
    end
    dmem_resp_valid = 1'b0;
    check_output("abort done_pulses", 64'(pulses), 64'd0);
    check_output("abort idle", 64'(req_ready), 64'd1);

    $display("[TB] randomized operations");
    for (int k = 0; k < 150; k++) begin
      kind = $urandom_range(9);
      rd   = 5'($urandom);
      imm  = 12'($urandom);
      base = {$urandom, $urandom};
      if ($urandom_range(3) != 0) begin
        base = base & ~64'h7;
        imm  = imm & ~12'h7;
      end
      if (kind < 4)       inst = enc_load(3'($urandom_range(6)), rd, imm);
      else if (kind < 8)  inst = enc_store(3'($urandom_range(3)), imm);
      else if (kind == 8) inst = $urandom;
      else                inst = enc_load(3'b111, rd, imm);
      v     = model(inst, base, {$urandom, $urandom}, {$urandom, $urandom});
      pct   = $urandom_range(30, 100);
      delay = $urandom_range(1, 3);
      apply_stimulus(v, pct, delay, 1'b1, o);
      check_op(v, o, delay);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
